// File: rtl/computer_pkg.sv
// Shared constants and state encoding for the byte computer's program memory loader.
// Latency: n/a (package only).
// Backpressure: n/a.
package computer_pkg;

    localparam int DW    = 8;   // data width
    localparam int AW    = 5;   // address width
    localparam int DEPTH = 32;  // memory words

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DUMP  = 3'd4
    } state_t;

endpackage

// File: rtl/program_memory_loader_ram.sv
// 32x8 RAM with one synchronous write port and two asynchronous read ports (CPU, dump).
// Latency: write lands at the rising edge; reads are combinational (zero latency).
// Backpressure: none; the write port is owned by the loader's write mux.
//
// Ports:
//   clk                               write clock
//   i_we / i_waddr / i_wdata          single write port
//   i_raddr_cpu  -> o_rdata_cpu       CPU read port
//   i_raddr_dump -> o_rdata_dump      dump read port
module ram32x8
    import computer_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_cpu,
    output logic [DW-1:0] o_rdata_cpu,
    input  logic [AW-1:0] i_raddr_dump,
    output logic [DW-1:0] o_rdata_dump
);

    // Contents are deliberately not reset; the loader zeroes them in CLEAR.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_cpu  = r_mem[i_raddr_cpu];
    assign o_rdata_dump = r_mem[i_raddr_dump];

endmodule

// File: rtl/program_memory_loader.sv
// Clears memory, loads a program from a byte stream, runs the computer, then dumps all 32 bytes.
// Latency: CLEAR 32 cycles; one byte per handshake in LOAD/DUMP; CPU reads zero-latency.
// Backpressure: in_ready only in HDR/LOAD; dump holds out_data stable until out_ready.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready/in_data          load stream (header byte = len-1, then len bytes)
//   cpu_start/cpu_halt                 run enable to / halt from the computer
//   cpu_addr/cpu_we/cpu_odata/cpu_idata computer memory port
//   out_valid/out_ready/out_data       dump stream
//   run_cycles, timeout, done          run statistics and dump completion pulse
module program_memory_loader
    import computer_pkg::*;
#(
    parameter logic [15:0] RUN_LIMIT = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          cpu_start,
    input  logic          cpu_halt,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_odata,
    output logic [DW-1:0] cpu_idata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [15:0]   run_cycles,
    output logic          timeout,
    output logic          done
);

    state_t        r_state, w_next;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic [AW:0]   r_len, w_len_nxt;   // 1..32 needs one extra bit
    logic          r_start;
    logic          r_timeout, w_timeout_nxt;
    logic          r_done, w_done_nxt;
    logic [15:0]   r_run_cycles;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_dump_rd;
    logic          w_in_hs, w_out_hs, w_limit;

    assign in_ready  = (r_state == ST_HDR) || (r_state == ST_LOAD);
    assign out_valid = (r_state == ST_DUMP);
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    assign w_limit   = (r_run_cycles == RUN_LIMIT);

    // Next state, pointer and the clear/load/CPU write mux.
    always_comb begin
        w_next        = r_state;
        w_ptr_nxt     = r_ptr;
        w_len_nxt     = r_len;
        w_timeout_nxt = r_timeout;
        w_done_nxt    = 1'b0;
        w_we          = 1'b0;
        w_waddr       = r_ptr;
        w_wdata       = '0;
        case (r_state)
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == AW'(DEPTH - 1)) begin
                    w_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_in_hs) begin
                    w_len_nxt = {1'b0, in_data[AW-1:0]} + 1'b1;
                    w_ptr_nxt = '0;
                    w_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_in_hs) begin
                    w_we    = 1'b1;
                    w_wdata = in_data;
                    if ({1'b0, r_ptr} == r_len - 1'b1) begin
                        w_ptr_nxt = '0;
                        w_next    = ST_RUN;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_we    = cpu_we;
                w_waddr = cpu_addr;
                w_wdata = cpu_odata;
                // Halt has priority over the cycle limit.
                if (cpu_halt) begin
                    w_timeout_nxt = 1'b0;
                    w_next        = ST_DUMP;
                end else if (w_limit) begin
                    w_timeout_nxt = 1'b1;
                    w_next        = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (w_out_hs) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == AW'(DEPTH - 1)) begin
                        w_done_nxt = 1'b1;
                        w_next     = ST_CLEAR;
                    end
                end
            end
            default: begin
                w_next    = ST_CLEAR;
                w_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLEAR;
            r_ptr        <= '0;
            r_len        <= '0;
            r_start      <= 1'b0;
            r_timeout    <= 1'b0;
            r_done       <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            r_state   <= w_next;
            r_ptr     <= w_ptr_nxt;
            r_len     <= w_len_nxt;
            r_timeout <= w_timeout_nxt;
            r_done    <= w_done_nxt;
            // Registered so it is high exactly on RUN cycles.
            r_start   <= (w_next == ST_RUN);
            if (r_state != ST_RUN && w_next == ST_RUN) begin
                r_run_cycles <= '0;
            end else if (r_state == ST_RUN && !w_limit) begin
                r_run_cycles <= r_run_cycles + 16'd1;
            end
        end
    end

    ram32x8 u_ram (
        .clk          (clk),
        .i_we         (w_we),
        .i_waddr      (w_waddr),
        .i_wdata      (w_wdata),
        .i_raddr_cpu  (cpu_addr),
        .o_rdata_cpu  (cpu_idata),
        .i_raddr_dump (r_ptr),
        .o_rdata_dump (w_dump_rd)
    );

    assign cpu_start  = r_start;
    assign out_data   = out_valid ? w_dump_rd : '0;
    assign run_cycles = r_run_cycles;
    assign timeout    = r_timeout;
    assign done       = r_done;

endmodule

// File: tb/tb_program_memory_loader.sv
`timescale 1ns/1ps
module tb_program_memory_loader;

    localparam logic [15:0] LIMIT = 16'd100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        cpu_start;
    logic        cpu_halt = 1'b0;
    logic [4:0]  cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_odata = '0;
    logic [7:0]  cpu_idata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [15:0] run_cycles;
    logic        timeout;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [7:0] sh [32];      // shadow of expected memory contents
    logic [7:0] prog [$];     // program bytes for load_prog
    logic [7:0] exp_q [$];    // dump scoreboard

    always #5 clk = ~clk;

    program_memory_loader #(.RUN_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cpu_start  (cpu_start),
        .cpu_halt   (cpu_halt),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_odata  (cpu_odata),
        .cpu_idata  (cpu_idata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .run_cycles (run_cycles),
        .timeout    (timeout),
        .done       (done)
    );

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cpu_we = 1'b0; cpu_halt = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at the negedge where rst_n was released; checks CLEAR length.
    task automatic check_clear_len();
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            #1;
            if (i == 31) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_len31: in_ready=%b want 0", in_ready); end
            end
            if (i == 32) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_len32: in_ready=%b want 1", in_ready); end
            end
        end
    endtask

    // Entered and left at a negedge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1; in_data = b;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin errors++; $display("FAIL send_timeout: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_prog();
        foreach (sh[i]) sh[i] = 8'h00;
        send_byte(8'(prog.size() - 1));
        foreach (prog[i]) begin
            send_byte(prog[i]);
            sh[i] = prog[i];
        end
        #1;
        checks++;
        if (cpu_start !== 1'b1) begin errors++; $display("FAIL start_rise: cpu_start=%b want 1", cpu_start); end
    endtask

    task automatic halt_now();
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        #1;
        checks++;
        if (cpu_start !== 1'b0) begin errors++; $display("FAIL start_fall: cpu_start=%b want 0", cpu_start); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL halt_timeout: timeout=%b want 0", timeout); end
    endtask

    task automatic dump_and_check(input bit stall_mode);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int got = 0;
        int n = 0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] e;
        foreach (sh[i]) exp_q.push_back(sh[i]);
        while (got < 32 && n < 2000) begin
            out_ready = stall_mode ? pat[n % 4] : 1'b1;
            #1;
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin errors++; $display("FAIL stall_stable: out_data=%h want %h", out_data, held); end
                end
                if (out_ready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (out_data !== e) begin errors++; $display("FAIL dump_byte%0d: out_data=%h want %h", got, out_data, e); end
                    got++;
                    stalled = 1'b0;
                end else begin
                    held = out_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != 32) begin errors++; $display("FAIL dump_count: got=%0d want 32", got); end
        #1;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b out_valid=%b want 1 0", done, out_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_once: done=%b want 0", done); end
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({in_ready, cpu_start, out_valid, timeout, done} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: rdy,start,ovld,to,done=%b want 00000", {in_ready, cpu_start, out_valid, timeout, done});
        end
        checks++;
        if (out_data !== 8'h00 || run_cycles !== 16'h0) begin
            errors++; $display("FAIL reset_data: out_data=%h run_cycles=%0d want 00 0", out_data, run_cycles);
        end
        check_clear_len();
    endtask

    task automatic test_empty_run();
        prog = '{8'hFF};
        load_prog();
        cpu_addr = 5'd0; #1;
        checks++;
        if (cpu_idata !== 8'hFF) begin errors++; $display("FAIL empty_read0: cpu_idata=%h want ff", cpu_idata); end
        cpu_addr = 5'd1; #1;
        checks++;
        if (cpu_idata !== 8'h00) begin errors++; $display("FAIL empty_read1: cpu_idata=%h want 00", cpu_idata); end
        halt_now();
        checks++;
        if (run_cycles !== 16'd1) begin errors++; $display("FAIL empty_cycles: run_cycles=%0d want 1", run_cycles); end
        dump_and_check(1'b0);
    endtask

    task automatic test_timeout();
        int cnt = 1;
        prog = '{8'hE0};
        load_prog();
        while (cpu_start && cnt < 400) begin
            @(negedge clk);
            #1;
            if (cpu_start) cnt++;
        end
        checks++;
        if (cnt < int'(LIMIT) || cnt > int'(LIMIT) + 1) begin errors++; $display("FAIL limit_len: start_cycles=%0d want %0d..%0d", cnt, LIMIT, LIMIT + 1); end
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL limit_flag: timeout=%b want 1", timeout); end
        checks++;
        if (run_cycles !== LIMIT) begin errors++; $display("FAIL limit_cycles: run_cycles=%0d want %0d", run_cycles, LIMIT); end
        dump_and_check(1'b0);
    endtask

    task automatic test_program();
        prog = '{8'h05, 8'h06, 8'h07, 8'hFF, 8'h00, 8'h03, 8'h04};
        load_prog();
        cpu_addr = 5'd5; #1;
        checks++;
        if (cpu_idata !== sh[5]) begin errors++; $display("FAIL prog_read5: cpu_idata=%h want %h", cpu_idata, sh[5]); end
        @(negedge clk);
        cpu_addr = 5'd6; #1;
        checks++;
        if (cpu_idata !== sh[6]) begin errors++; $display("FAIL prog_read6: cpu_idata=%h want %h", cpu_idata, sh[6]); end
        @(negedge clk);
        cpu_addr = 5'd7; cpu_we = 1'b1; cpu_odata = 8'h07;
        sh[7] = 8'h07;
        @(negedge clk);
        cpu_we = 1'b0; #1;
        checks++;
        if (cpu_idata !== 8'h07) begin errors++; $display("FAIL prog_write7: cpu_idata=%h want 07", cpu_idata); end
        halt_now();
        checks++;
        if (run_cycles !== 16'd4) begin errors++; $display("FAIL prog_cycles: run_cycles=%0d want 4", run_cycles); end
        dump_and_check(1'b0);
    endtask

    task automatic test_back_to_back();
        prog.delete();
        for (int i = 0; i < 32; i++) prog.push_back(8'($urandom_range(1, 255)));
        load_prog();
        halt_now();
        dump_and_check(1'b1);
    endtask

    task automatic test_reset_mid_load();
        send_byte(8'h05);
        send_byte(8'hA1);
        send_byte(8'hA2);
        in_valid = 1'b1; in_data = 8'hA3;
        rst_n = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b0 || cpu_start !== 1'b0) begin errors++; $display("FAIL midload_reset: in_ready=%b cpu_start=%b want 0 0", in_ready, cpu_start); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_clear_len();
        prog = '{8'h5A};
        load_prog();
        halt_now();
        dump_and_check(1'b0);
    endtask

    task automatic test_ignore_inputs();
        // Still in CLEAR after the previous dump.
        in_valid = 1'b1; in_data = 8'hAA;
        cpu_we = 1'b1; cpu_addr = 5'd20; cpu_odata = 8'h99;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready%0d: in_ready=%b want 0", i, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        foreach (sh[i]) sh[i] = 8'h00;
        sh[0] = 8'h11; sh[1] = 8'h22;
        send_byte(8'h01);
        send_byte(8'h11);
        cpu_we = 1'b0;
        send_byte(8'h22);
        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || cpu_start !== 1'b1) begin errors++; $display("FAIL run_ready%0d: in_ready=%b cpu_start=%b want 0 1", i, in_ready, cpu_start); end
            @(negedge clk);
        end
        halt_now();
        in_valid = 1'b0;
        dump_and_check(1'b0);
    endtask

    initial begin
        test_reset();
        test_empty_run();
        test_timeout();
        test_program();
        test_back_to_back();
        test_reset_mid_load();
        test_ignore_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

32×8 unified program/data memory with a byte-stream loader and result dumper for the byte computer. It clears memory, accepts a program over a valid/ready byte stream, and holds `cpu_start` high while the computer runs. When the computer halts or a cycle limit expires, it streams all 32 memory bytes back out. It serves the computer's `addr`/`idata`/`odata`/`we` port directly.

## Interface
- `DEPTH`, 32, memory words (fixed at 32; address width 5)
- `DW`, 8, data width
- `RUN_LIMIT`, 16'hFFFF, max RUN cycles before forced abort
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  load-stream byte valid
- `in_ready`  out  1  load-stream ready
- `in_data`  in  8  load-stream byte
- `cpu_start`  out  1  run enable to computer `start`
- `cpu_halt`  in  1  computer `halt`
- `cpu_addr`  in  5  computer `addr`
- `cpu_we`  in  1  computer `we`
- `cpu_odata`  in  8  computer `odata` (write data)
- `cpu_idata`  out  8  computer `idata` (read data)
- `out_valid`  out  1  dump-stream valid
- `out_ready`  in  1  dump-stream ready
- `out_data`  out  8  dump-stream byte
- `run_cycles`  out  16  cycles spent in last/current RUN
- `timeout`  out  1  last run ended by `RUN_LIMIT`
- `done`  out  1  one-cycle pulse when dump completes

## Operation
- FSM states: CLEAR, HDR, LOAD, RUN, DUMP. Reset → CLEAR.
- CLEAR: write 0 to mem[ptr], ptr 0→31, one word per cycle; after word 31 → HDR. `in_ready`=0.
- HDR: `in_ready`=1; on handshake, len = `in_data[4:0]` + 1 (1..32; bits [7:5] ignored), ptr←0 → LOAD.
- LOAD: `in_ready`=1; each handshake writes mem[ptr]←`in_data`, ptr++. After the len-th byte → RUN. Unloaded words remain 0.
- RUN: `cpu_start`=1 (registered). `run_cycles` cleared on entry and incremented each RUN cycle. Write mem[`cpu_addr`]←`cpu_odata` on any cycle with `cpu_we`=1.
  - `cpu_halt` sampled 1 → DUMP, `timeout`←0.
  - `run_cycles`==`RUN_LIMIT` → DUMP, `timeout`←1.
  - If both occur together, halt wins (`timeout`=0).
- DUMP: `out_valid`=1, `out_data`=mem[ptr] with ptr from 0. Advance ptr on handshake. `out_data` stays stable while stalled. After the handshake at ptr 31: pulse `done`, then → CLEAR.
- `cpu_idata` = mem[`cpu_addr`] combinationally, in all states.
- `cpu_we` is ignored outside RUN.
- `in_data` is ignored outside HDR/LOAD; `in_ready` is 0 there.

## Timing
- Reset values: `in_ready`=0, `cpu_start`=0, `out_valid`=0, `out_data`=0, `run_cycles`=0, `timeout`=0, `done`=0, ptr=0. Memory contents are not reset; CLEAR zeroes them.
- Reset assertion mid-operation forces CLEAR immediately and drops `cpu_start` asynchronously. The computer re-initialises on the next `start` rise.
- CLEAR lasts exactly 32 cycles. First HDR `in_ready` is high on cycle 33 after reset release.
- Writes (loader, CPU, clear) take effect at the rising edge. CPU reads are zero-latency (asynchronous read).
- `cpu_start` rises on the first RUN cycle and falls on the cycle after halt or limit is sampled. The computer's internal reset on `start`=0 is relied on.
- `run_cycles` stops counting outside RUN and holds its value until the next RUN entry. It never wraps; the limit fires first.
- Handshake rule: transfer on `valid && ready` at the rising edge. The source holds data until transfer.

## Structure
- Shared package (`computer_pkg`): `DW`, address width 5, `DEPTH`, state enum {CLEAR, HDR, LOAD, RUN, DUMP}.
- One natural sub-module: `ram32x8`, with one synchronous write port and two asynchronous read ports (CPU, dump). The write mux (clear/load/CPU) lives in the loader.

## Test plan
- Reset, then wait 32 cycles → `in_ready` rises on cycle 33. Dump of an empty run: header 0x00, byte 0xFF (JMP halt) → halt; DUMP yields 0xFF then 31×0x00.
- Program: LD 0x05, ADD 0x06, ST 0x07, JMP-halt 0xFF, with mem[5]=0x03 and mem[6]=0x04 (header 0x06) → dump shows mem[7]=0x07, `timeout`=0, `done` pulses once.
- Header 0x00 with a single byte 0xE0 (unconditional-jump loop), `RUN_LIMIT`=100 → `cpu_start` falls after 100 cycles, `timeout`=1, `run_cycles`=100.
- Dump with `out_ready` toggling 1,0,0,1 → every byte is delivered exactly once in order, and `out_data` is stable during stalls.
- Assert `rst_n`=0 during LOAD (byte 3 of 6), then reload → first dump shows only the new program; no stale bytes remain.
- `in_valid`=1 held during CLEAR and RUN → no bytes are consumed and memory is unchanged.
